// File: rtl/de_pipe_grf.sv
`default_nettype none
// ============================================================================
//  Module   : de_pipe_grf
//  Purpose  : Decode-stage general register file with write-through bypass,
//             per-port E/M/W forwarding muxes, load-use hazard detection and
//             the D/E pipeline register (separate hold and bubble controls).
//  Revision : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   clock, all state changes on the rising edge
//    reset       in   synchronous active-low reset
//    d_valid     in   D stage holds a real instruction
//    d_raddr     in   NUM_RD read addresses, port i at [i*AW +: AW]
//    d_fwd_sel   in   per port: 00 GRF/bypass, 01 e_fwd, 10 m_fwd, 11 w_data
//    d_waddr     in   destination register decoded in D (0 = none)
//    d_payload   in   opaque instr/PC/immediate bundle carried to E
//    e_fwd       in   forwarding value from E
//    m_fwd       in   forwarding value from M
//    e_is_load   in   instruction in E is a load
//    w_en        in   write-back enable
//    w_addr      in   write-back address
//    w_data      in   write-back data
//    w_pc        in   PC of the writing instruction (trace only)
//    de_stall    in   hold the D/E register
//    de_flush    in   load a bubble into the D/E register (beats de_stall)
//    d_rdata     out  combinational forwarded read data
//    d_load_use  out  combinational load-use hazard request
//    de_valid    out  registered valid
//    de_rdata    out  registered read data
//    de_waddr    out  registered destination
//    de_payload  out  registered payload
// ----------------------------------------------------------------------------
//  Build option
//    GRF_WRITE_TRACE_EN : when defined, every committed write prints
//                         "<time>@<pc>: $<reg> <= <data>".
// ============================================================================
module de_pipe_grf #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int PAY_W  = 96,
    parameter int PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_valid,
    input  logic [NUM_RD*AW-1:0]     d_raddr,
    input  logic [NUM_RD*2-1:0]      d_fwd_sel,
    input  logic [AW-1:0]            d_waddr,
    input  logic [PAY_W-1:0]         d_payload,
    input  logic [DATA_W-1:0]        e_fwd,
    input  logic [DATA_W-1:0]        m_fwd,
    input  logic                     e_is_load,
    input  logic                     w_en,
    input  logic [AW-1:0]            w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [PC_W-1:0]          w_pc,
    input  logic                     de_stall,
    input  logic                     de_flush,
    output logic [NUM_RD*DATA_W-1:0] d_rdata,
    output logic                     d_load_use,
    output logic                     de_valid,
    output logic [NUM_RD*DATA_W-1:0] de_rdata,
    output logic [AW-1:0]            de_waddr,
    output logic [PAY_W-1:0]         de_payload
);

    localparam int c_DEPTH = 1 << AW;

    logic [DATA_W-1:0]        r_grf [c_DEPTH];
    logic                     r_de_valid;
    logic [NUM_RD*DATA_W-1:0] r_de_rdata;
    logic [AW-1:0]            r_de_waddr;
    logic [PAY_W-1:0]         r_de_payload;

    logic                     w_commit;
    logic                     w_addr_hit;

    // Writes to r0 are dropped here so entry 0 stays at its reset value.
    assign w_commit = w_en && (w_addr != '0);

    // ------------------------------------------------------------------
    // Register file write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_grf[i] <= '0;
            end
        end else if (w_commit) begin
            r_grf[w_addr] <= w_data;
`ifdef GRF_WRITE_TRACE_EN
            $display("%0t@%h: $%0d <= %h", $time, w_pc, w_addr, w_data);
`endif
        end
    end

`ifndef GRF_WRITE_TRACE_EN
    // The trace PC has no consumer when tracing is compiled out.
    logic w_unused_pc;
    assign w_unused_pc = ^w_pc;
`endif

    // ------------------------------------------------------------------
    // Read ports: r0 / write-through bypass / array, then forwarding mux
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     w_raddr;
        logic [1:0]        w_sel;
        logic [DATA_W-1:0] w_base;
        logic [DATA_W-1:0] w_out;

        assign w_raddr = d_raddr[p*AW +: AW];
        assign w_sel   = d_fwd_sel[p*2 +: 2];

        always_comb begin
            w_base = r_grf[w_raddr];
            if (w_raddr == '0) begin
                w_base = '0;
            end else if (w_en && (w_addr == w_raddr)) begin
                w_base = w_data;
            end
        end

        // Forwarding overrides even r0; the decoder never selects it there.
        always_comb begin
            w_out = w_base;
            case (w_sel)
                2'b01:   w_out = e_fwd;
                2'b10:   w_out = m_fwd;
                2'b11:   w_out = w_data;
                default: w_out = w_base;
            endcase
        end

        assign d_rdata[p*DATA_W +: DATA_W] = w_out;
    end

    // ------------------------------------------------------------------
    // Load-use detection: a load in E whose destination D wants to read
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (d_raddr[i*AW +: AW] == r_de_waddr) begin
                w_addr_hit = 1'b1;
            end
        end
    end

    assign d_load_use = r_de_valid && e_is_load && (r_de_waddr != '0) &&
                        d_valid && w_addr_hit;

    // ------------------------------------------------------------------
    // D/E pipeline register: flush beats stall beats capture.
    // A held entry is not refreshed from write-back; E forwarding covers it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset || de_flush) begin
            r_de_valid   <= 1'b0;
            r_de_rdata   <= '0;
            r_de_waddr   <= '0;
            r_de_payload <= '0;
        end else if (!de_stall) begin
            r_de_valid   <= d_valid;
            r_de_rdata   <= d_rdata;
            r_de_waddr   <= d_valid ? d_waddr : '0;
            r_de_payload <= d_payload;
        end
    end

    assign de_valid   = r_de_valid;
    assign de_rdata   = r_de_rdata;
    assign de_waddr   = r_de_waddr;
    assign de_payload = r_de_payload;

endmodule
`default_nettype wire

// File: tb/tb_de_pipe_grf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_de_pipe_grf
//  Purpose  : Directed self-checking bench for de_pipe_grf (default params).
//             Inputs change 1 time unit after the rising edge; outputs are
//             compared 1 further unit later, well away from the next edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_de_pipe_grf;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;
    localparam int PAY_W  = 96;
    localparam int PC_W   = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     d_valid;
    logic [NUM_RD*AW-1:0]     d_raddr;
    logic [NUM_RD*2-1:0]      d_fwd_sel;
    logic [AW-1:0]            d_waddr;
    logic [PAY_W-1:0]         d_payload;
    logic [DATA_W-1:0]        e_fwd;
    logic [DATA_W-1:0]        m_fwd;
    logic                     e_is_load;
    logic                     w_en;
    logic [AW-1:0]            w_addr;
    logic [DATA_W-1:0]        w_data;
    logic [PC_W-1:0]          w_pc;
    logic                     de_stall;
    logic                     de_flush;
    logic [NUM_RD*DATA_W-1:0] d_rdata;
    logic                     d_load_use;
    logic                     de_valid;
    logic [NUM_RD*DATA_W-1:0] de_rdata;
    logic [AW-1:0]            de_waddr;
    logic [PAY_W-1:0]         de_payload;

    int n_pass  = 0;
    int n_total = 0;

    de_pipe_grf #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .NUM_RD (NUM_RD),
        .PAY_W  (PAY_W),
        .PC_W   (PC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_raddr    (d_raddr),
        .d_fwd_sel  (d_fwd_sel),
        .d_waddr    (d_waddr),
        .d_payload  (d_payload),
        .e_fwd      (e_fwd),
        .m_fwd      (m_fwd),
        .e_is_load  (e_is_load),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_pc       (w_pc),
        .de_stall   (de_stall),
        .de_flush   (de_flush),
        .d_rdata    (d_rdata),
        .d_load_use (d_load_use),
        .de_valid   (de_valid),
        .de_rdata   (de_rdata),
        .de_waddr   (de_waddr),
        .de_payload (de_payload)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        // Populate a few registers and a valid D/E entry.
        w_en = 1'b1; w_addr = 5'd1;  w_data = 32'h11; tick();
        w_addr = 5'd2;  w_data = 32'h22; tick();
        w_addr = 5'd31; w_data = 32'h33;
        d_valid = 1'b1; d_waddr = 5'd4; d_payload = 96'hABC;
        d_raddr = {5'd2, 5'd1}; tick();
        // Two reset edges, with a write and a flush/stall that must be ignored.
        reset = 1'b0; w_en = 1'b1; w_addr = 5'd7; w_data = 32'h77;
        de_stall = 1'b1; tick();
        de_stall = 1'b0; de_flush = 1'b1; tick();
        reset = 1'b1; w_en = 1'b0; de_flush = 1'b0; d_valid = 1'b0;
        d_raddr = {5'd2, 5'd1};
        #1;
        n_total++;
        if (d_rdata !== 64'h0) $display("FAIL reset_rd_1_2 got %h want 0", d_rdata);
        else n_pass++;
        d_raddr = {5'd7, 5'd31};
        #1;
        n_total++;
        if (d_rdata !== 64'h0) $display("FAIL reset_rd_31_7 got %h want 0 (write during reset lost)", d_rdata);
        else n_pass++;
        n_total++;
        if (de_valid !== 1'b0 || de_rdata !== 64'h0 || de_waddr !== 5'd0 || de_payload !== 96'h0)
            $display("FAIL reset_de got v=%b rd=%h wa=%0d pl=%h want all 0", de_valid, de_rdata, de_waddr, de_payload);
        else n_pass++;
    endtask

    task automatic test_bypass();
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
        d_raddr = {5'd0, 5'd5}; d_fwd_sel = 4'b0000;
        d_valid = 1'b1; d_waddr = 5'd6; d_payload = 96'h1234_5678;
        #1;
        n_total++;
        if (d_rdata[31:0] !== 32'hDEADBEEF) $display("FAIL bypass_comb got %h want deadbeef", d_rdata[31:0]);
        else n_pass++;
        tick();
        n_total++;
        if (de_rdata[31:0] !== 32'hDEADBEEF || de_valid !== 1'b1 || de_waddr !== 5'd6)
            $display("FAIL bypass_capture got rd=%h v=%b wa=%0d want deadbeef 1 6", de_rdata[31:0], de_valid, de_waddr);
        else n_pass++;
        w_en = 1'b0; w_data = 32'h0; d_raddr = {5'd5, 5'd5};
        #1;
        n_total++;
        if (d_rdata !== 64'hDEADBEEF_DEADBEEF) $display("FAIL bypass_stored_both got %h want deadbeefdeadbeef", d_rdata);
        else n_pass++;
    endtask

    task automatic test_r0();
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'h1234;
        d_raddr = {5'd0, 5'd0}; d_fwd_sel = 4'b0000;
        #1;
        n_total++;
        if (d_rdata !== 64'h0) $display("FAIL r0_no_bypass got %h want 0", d_rdata);
        else n_pass++;
        tick();
        w_en = 1'b0;
        #1;
        n_total++;
        if (d_rdata !== 64'h0) $display("FAIL r0_after_write got %h want 0", d_rdata);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        logic [31:0] exp [4];
        exp[0] = 32'h1; exp[1] = 32'hA; exp[2] = 32'hB; exp[3] = 32'hC;
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h1; tick();
        w_en = 1'b0; w_data = 32'hC; e_fwd = 32'hA; m_fwd = 32'hB;
        d_raddr = {5'd3, 5'd0};
        for (int s = 0; s < 4; s++) begin
            d_fwd_sel = {s[1:0], 2'b00};
            #1;
            n_total++;
            if (d_rdata[63:32] !== exp[s]) $display("FAIL fwd_sel%0d got %h want %h", s, d_rdata[63:32], exp[s]);
            else n_pass++;
        end
        d_fwd_sel = 4'b0000; e_fwd = '0; m_fwd = '0; w_data = '0;
    endtask

    task automatic test_stall_flush();
        // GRF[3]=1, GRF[5]=DEADBEEF from earlier tasks.
        d_valid = 1'b1; d_waddr = 5'd9; d_payload = 96'hFACE_0000_0001;
        d_raddr = {5'd5, 5'd3};
        tick();
        n_total++;
        if (de_valid !== 1'b1 || de_waddr !== 5'd9 || de_rdata !== 64'hDEADBEEF_00000001 || de_payload !== 96'hFACE_0000_0001)
            $display("FAIL capture_x got v=%b wa=%0d rd=%h pl=%h", de_valid, de_waddr, de_rdata, de_payload);
        else n_pass++;
        // Change D inputs and overwrite GRF[3]; held entry must not change.
        de_stall = 1'b1; d_waddr = 5'd10; d_payload = 96'h99; d_raddr = {5'd1, 5'd1};
        w_en = 1'b1; w_addr = 5'd3; w_data = 32'h77;
        for (int c = 0; c < 3; c++) begin
            tick();
            w_en = 1'b0;
            n_total++;
            if (de_valid !== 1'b1 || de_waddr !== 5'd9 || de_rdata !== 64'hDEADBEEF_00000001 || de_payload !== 96'hFACE_0000_0001)
                $display("FAIL stall_hold%0d got v=%b wa=%0d rd=%h pl=%h", c, de_valid, de_waddr, de_rdata, de_payload);
            else n_pass++;
        end
        de_flush = 1'b1;
        tick();
        n_total++;
        if (de_valid !== 1'b0 || de_waddr !== 5'd0 || de_rdata !== 64'h0 || de_payload !== 96'h0)
            $display("FAIL flush_over_stall got v=%b wa=%0d rd=%h pl=%h want all 0", de_valid, de_waddr, de_rdata, de_payload);
        else n_pass++;
        // Invalid capture: waddr forced to 0, payload still captured.
        de_flush = 1'b0; de_stall = 1'b0; d_valid = 1'b0; d_waddr = 5'd12; d_payload = 96'h55;
        d_raddr = {5'd0, 5'd3};
        tick();
        n_total++;
        if (de_valid !== 1'b0 || de_waddr !== 5'd0 || de_payload !== 96'h55 || de_rdata !== 64'h00000000_00000077)
            $display("FAIL invalid_capture got v=%b wa=%0d pl=%h rd=%h", de_valid, de_waddr, de_payload, de_rdata);
        else n_pass++;
    endtask

    task automatic test_load_use();
        d_valid = 1'b1; d_waddr = 5'd8; d_raddr = {5'd0, 5'd0};
        tick();
        e_is_load = 1'b1; d_raddr = {5'd8, 5'd2};
        #1;
        n_total++;
        if (d_load_use !== 1'b1) $display("FAIL lu_hit got %b want 1", d_load_use);
        else n_pass++;
        d_raddr = {5'd9, 5'd2};
        #1;
        n_total++;
        if (d_load_use !== 1'b0) $display("FAIL lu_miss9 got %b want 0", d_load_use);
        else n_pass++;
        d_raddr = {5'd0, 5'd0};
        #1;
        n_total++;
        if (d_load_use !== 1'b0) $display("FAIL lu_r0 got %b want 0", d_load_use);
        else n_pass++;
        d_raddr = {5'd8, 5'd2}; e_is_load = 1'b0;
        #1;
        n_total++;
        if (d_load_use !== 1'b0) $display("FAIL lu_not_load got %b want 0", d_load_use);
        else n_pass++;
        e_is_load = 1'b1; d_valid = 1'b0;
        #1;
        n_total++;
        if (d_load_use !== 1'b0) $display("FAIL lu_d_invalid got %b want 0", d_load_use);
        else n_pass++;
        d_valid = 1'b1; de_flush = 1'b1;
        tick();
        de_flush = 1'b0;
        #1;
        n_total++;
        if (d_load_use !== 1'b0) $display("FAIL lu_e_bubble got %b want 0", d_load_use);
        else n_pass++;
        // Valid E entry with destination r0 must not raise a hazard on r0 reads.
        d_waddr = 5'd0;
        tick();
        d_raddr = {5'd0, 5'd0};
        #1;
        n_total++;
        if (d_load_use !== 1'b0) $display("FAIL lu_dest_r0 got %b want 0", d_load_use);
        else n_pass++;
        e_is_load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; d_valid = 1'b0; d_raddr = '0; d_fwd_sel = '0; d_waddr = '0;
        d_payload = '0; e_fwd = '0; m_fwd = '0; e_is_load = 1'b0; w_en = 1'b0;
        w_addr = '0; w_data = '0; w_pc = 32'h0000_3000; de_stall = 1'b0; de_flush = 1'b0;
        tick();
        tick();
        test_reset();
        test_bypass();
        test_r0();
        test_forwarding();
        test_stall_flush();
        test_load_use();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
